// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver that reassembles groups of FRAME_BYTES
// bytes into one word. It flags stop-bit errors and stalls between bytes of
// a partially assembled frame.
module uart_frame_rx #(
    parameter int BAUD_DIV    = 434,
    parameter int FRAME_BYTES = 5,
    parameter int GAP_BITS    = 20
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     busy
);
    localparam int DW        = 8 * FRAME_BYTES;
    localparam int HALF_DIV  = BAUD_DIV / 2;
    localparam int GAP_LIMIT = GAP_BITS * BAUD_DIV;
    localparam int BW        = $clog2(BAUD_DIV);
    localparam int GW        = $clog2(GAP_LIMIT + 1);
    localparam int CW        = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic            rx_meta, rxs, rxs_prev;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   frame_buf, buf_next;
    logic [GW-1:0]   gap_cnt;
    logic            start_seen, half_tick, bit_tick;
    logic            start_ok, data_sample, byte_good, byte_bad;
    logic            gap_timeout, frame_done;

    // Bring the asynchronous line into the clock domain and keep one older copy for edge detection
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= uart_rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign start_seen = (state == IDLE) && rxs_prev && !rxs;
    assign half_tick  = (baud_cnt == BW'(HALF_DIV - 1));
    assign bit_tick   = (baud_cnt == BW'(BAUD_DIV - 1));

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a start bit that reads high at mid-bit is a false start
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_seen) state_next = START;
            START:   if (half_tick) state_next = rxs ? IDLE : DATA;
            DATA:    if (bit_tick && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: one-cycle sample strobes for each phase of the byte
    always_comb begin
        start_ok    = 1'b0;
        data_sample = 1'b0;
        byte_good   = 1'b0;
        byte_bad    = 1'b0;
        case (state)
            START: start_ok = half_tick && !rxs;
            DATA:  data_sample = bit_tick;
            STOP: begin
                byte_good = bit_tick && rxs;
                byte_bad  = bit_tick && !rxs;
            end
            default: ;
        endcase
    end

    assign frame_done  = byte_good && (cnt == CW'(FRAME_BYTES - 1));
    assign gap_timeout = (state == IDLE) && (cnt != '0) && !start_seen &&
                         (gap_cnt == GW'(GAP_LIMIT - 1));
    assign busy        = (state != IDLE) || (cnt != '0);

    // Baud counter restarts at every sample point so later samples stay at mid-bit
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            baud_cnt <= '0;
        else if (state == IDLE)
            baud_cnt <= '0;
        else if ((state == START && half_tick) || (state != START && bit_tick))
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + BW'(1);
    end

    // Shift data bits in LSB first at their own bit position
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else if (start_ok) begin
            bit_idx <= 3'd0;
        end else if (data_sample) begin
            shift_reg[bit_idx] <= rxs;
            bit_idx            <= bit_idx + 3'd1;
        end
    end

    // Place the received byte into its slot; the first byte lands in the top slot
    always_comb begin
        buf_next = frame_buf;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (cnt == CW'(i)) buf_next[(FRAME_BYTES-1-i)*8 +: 8] = shift_reg;
        end
    end

    // Idle time between bytes of a partial frame; any start detection clears it
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            gap_cnt <= '0;
        else if (state == IDLE && cnt != '0 && !start_seen && !gap_timeout)
            gap_cnt <= gap_cnt + GW'(1);
        else
            gap_cnt <= '0;
    end

    // Frame assembly: publish complete frames, drop partial ones on any error
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            frame_buf   <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (byte_good) begin
                frame_buf <= buf_next;
                if (frame_done) begin
                    frame_data  <= buf_next;
                    frame_valid <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (byte_bad || gap_timeout) begin
                cnt       <= '0;
                frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx at BAUD_DIV=16, FRAME_BYTES=5, GAP_BITS=20.
module tb_uart_frame_rx;
    localparam int BAUD_DIV    = 16;
    localparam int FRAME_BYTES = 5;
    localparam int GAP_BITS    = 20;
    localparam int GAP_CYCLES  = GAP_BITS * BAUD_DIV;
    localparam int NUM_VECS    = 8;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic [39:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    uart_frame_rx #(
        .BAUD_DIV   (BAUD_DIV),
        .FRAME_BYTES(FRAME_BYTES),
        .GAP_BITS   (GAP_BITS)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          n_bytes;
        logic [63:0] bytes;
        logic [7:0]  bad_mask;
        int          idle_after;
        logic        exp_busy_mid;
        logic [39:0] exp_data;
        int          exp_valid;
        int          exp_err;
    } vec_t;

    vec_t        vecs[NUM_VECS];
    int          compares    = 0;
    int          miscompares = 0;
    int          valid_count = 0;
    int          err_count   = 0;
    logic [39:0] got_frames[$];
    int          base_v, base_e, base_q;

    // Record every strobe seen on the outputs, sampled away from the active edge
    always @(negedge sys_clk) begin
        if (frame_valid) begin
            valid_count++;
            got_frames.push_back(frame_data);
        end
        if (frame_err) err_count++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        wait_cycles(BAUD_DIV);
    endtask

    // A byte with a bad stop bit is followed by two idle bits so the next start edge is visible
    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(!bad_stop);
        if (bad_stop) begin
            uart_rx = 1'b1;
            wait_cycles(2 * BAUD_DIV);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
        compares++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.n_bytes; i++)
            send_byte(v.bytes[63-8*i -: 8], v.bad_mask[i]);
        uart_rx = 1'b1;
        wait_cycles(20);
    endtask

    task automatic checkOutput(input string name, input logic [39:0] exp_data,
                               input int exp_valid, input int exp_err);
        checkValue({name, " valid pulses"}, 64'(valid_count - base_v), 64'(exp_valid));
        checkValue({name, " err pulses"}, 64'(err_count - base_e), 64'(exp_err));
        checkValue({name, " frame_data"}, {24'h0, frame_data}, {24'h0, exp_data});
    endtask

    logic [39:0] exp_frames[$];
    logic [7:0]  partial[$];
    int          exp_errs;
    logic [7:0]  rb;
    logic        rbad;
    logic        rlong;
    logic [39:0] w;

    initial begin
        vecs[0] = '{5, 64'h1008040201_000000, 8'h00, 20, 1'b0, 40'h1008040201, 1, 0};
        vecs[1] = '{8, 64'h112233AABBCCDDEE,  8'h04, 20, 1'b0, 40'hAABBCCDDEE, 1, 1};
        vecs[2] = '{3, 64'h010203_0000000000, 8'h00, GAP_CYCLES, 1'b1, 40'hAABBCCDDEE, 0, 1};
        vecs[3] = '{5, 64'h0102030405_000000, 8'h00, 20, 1'b0, 40'h0102030405, 1, 0};
        vecs[4] = '{5, 64'hFFFFFFFFFF_000000, 8'h00, 20, 1'b0, 40'hFFFFFFFFFF, 1, 0};
        vecs[5] = '{5, 64'h5AA53CC37E_000000, 8'h10, 20, 1'b0, 40'hFFFFFFFFFF, 0, 1};
        vecs[6] = '{5, 64'h0000000000_000000, 8'h00, 20, 1'b0, 40'h0000000000, 1, 0};
        vecs[7] = '{5, 64'hDEADBEEF42_000000, 8'h00, 20, 1'b0, 40'hDEADBEEF42, 1, 0};

        rst     = 1'b1;
        uart_rx = 1'b1;
        wait_cycles(4);
        checkValue("reset frame_data", {24'h0, frame_data}, 64'h0);
        checkValue("reset frame_valid", frame_valid, 0);
        checkValue("reset frame_err", frame_err, 0);
        checkValue("reset busy", busy, 0);
        rst = 1'b0;
        wait_cycles(4);

        // Table of frames, including framing errors and a gap timeout
        for (int k = 0; k < NUM_VECS; k++) begin
            base_v = valid_count;
            base_e = err_count;
            applyStimulus(vecs[k]);
            checkValue($sformatf("vec%0d busy", k), busy, vecs[k].exp_busy_mid);
            wait_cycles(vecs[k].idle_after);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_data,
                        vecs[k].exp_valid, vecs[k].exp_err);
        end

        // Short low glitch must be rejected as a false start
        base_v  = valid_count;
        base_e  = err_count;
        uart_rx = 1'b0;
        wait_cycles(3);
        uart_rx = 1'b1;
        wait_cycles(20);
        checkValue("glitch busy", busy, 0);
        applyStimulus('{5, 64'h3141592653_000000, 8'h00, 0, 1'b0, 40'h0, 0, 0});
        checkOutput("false start", 40'h3141592653, 1, 0);

        // Reset asserted during bit 4 of the third byte
        base_v = valid_count;
        base_e = err_count;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        uart_rx = 1'b1;
        wait_cycles(BAUD_DIV / 2);
        checkValue("pre-reset busy", busy, 1);
        rst = 1'b1;
        #1;
        checkValue("mid reset frame_data", {24'h0, frame_data}, 64'h0);
        checkValue("mid reset frame_valid", frame_valid, 0);
        checkValue("mid reset frame_err", frame_err, 0);
        checkValue("mid reset busy", busy, 0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(4);
        applyStimulus('{5, 64'h5566778899_000000, 8'h00, 0, 1'b0, 40'h0, 0, 0});
        checkOutput("after reset", 40'h5566778899, 1, 0);

        // Random byte stream checked against a queue-based frame model
        base_e   = err_count;
        base_q   = got_frames.size();
        exp_errs = 0;
        for (int n = 0; n < 60; n++) begin
            rb    = 8'($urandom);
            rbad  = ($urandom_range(0, 9) == 0);
            rlong = ($urandom_range(0, 7) == 0);
            send_byte(rb, rbad);
            uart_rx = 1'b1;
            if (rbad) begin
                partial.delete();
                exp_errs++;
            end else begin
                partial.push_back(rb);
                if (partial.size() == FRAME_BYTES) begin
                    w = 40'h0;
                    foreach (partial[j]) w = {w[31:0], partial[j]};
                    exp_frames.push_back(w);
                    partial.delete();
                end
            end
            if (rlong) begin
                wait_cycles(GAP_CYCLES + 80);
                if (partial.size() != 0) begin
                    partial.delete();
                    exp_errs++;
                end
            end else begin
                wait_cycles(BAUD_DIV * int'($urandom_range(0, 3)));
            end
        end
        wait_cycles(GAP_CYCLES + 80);
        if (partial.size() != 0) begin
            partial.delete();
            exp_errs++;
        end
        checkValue("random frame count", 64'(got_frames.size() - base_q), 64'(exp_frames.size()));
        checkValue("random err count", 64'(err_count - base_e), 64'(exp_errs));
        for (int i = 0; i < exp_frames.size(); i++) begin
            if (base_q + i < got_frames.size())
                checkValue($sformatf("random frame %0d", i),
                           {24'h0, got_frames[base_q + i]}, {24'h0, exp_frames[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", compares, miscompares);
        $finish;
    end

    initial begin
        rb = 8'h56;
    end
endmodule
